// File: rtl/monitor_event_drain.sv
// Samples a monitored bus and queues an event on enable or value change; FWFT event FIFO drains over valid/ready.
// Latency: sample at edge N is visible as evt_valid after edge N when the queue was empty.
// Backpressure: evt_ready=0 holds the head; pushes to a full queue are dropped and counted (MONITOR_TIMESTAMP_EN adds timestamps).
module monitor_event_drain #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int TS_W       = 16,
  parameter int STROBE_THR = 100
) (
  input  logic                      clk_monitor,
  input  logic                      rst_monitor,
  input  logic [DATA_W-1:0]         data_in_monitor,
  input  logic                      enable_monitor,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [DATA_W-1:0]         evt_data,
  output logic                      evt_strobe,
  output logic [TS_W-1:0]           evt_ts,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [7:0]                overflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [DATA_W-1:0] THR      = DATA_W'(STROBE_THR);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              strobe;
`ifdef MONITOR_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } evt_t;

  logic [DATA_W-1:0] last_q;
  logic              armed;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  evt_t              mem [DEPTH];
  evt_t              new_evt;
  evt_t              head;

  logic capture;
  logic full;
  logic pop;
  logic do_write;
  logic drop;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == FULL_LVL);
  assign evt_valid  = (fifo_level != '0);
  assign pop        = evt_valid && evt_ready;

  // First enabled cycle after idle always reports, afterwards only on change.
  assign capture  = enable_monitor && (!armed || (data_in_monitor != last_q));
  // A pop in the same cycle frees the slot the full-queue push lands in.
  assign do_write = capture && (!full || pop);
  assign drop     = capture && full && !pop;

`ifdef MONITOR_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_monitor or posedge rst_monitor) begin
    if (rst_monitor) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end
`endif

  always_comb begin
    new_evt        = '0;
    new_evt.data   = data_in_monitor;
    new_evt.strobe = (data_in_monitor > THR);
`ifdef MONITOR_TIMESTAMP_EN
    new_evt.ts     = ts_q;
`endif
  end

  always_ff @(posedge clk_monitor or posedge rst_monitor) begin
    if (rst_monitor) begin
      armed          <= 1'b0;
      last_q         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      overflow_count <= '0;
    end else begin
      if (!enable_monitor) begin
        armed <= 1'b0;
      end else begin
        armed <= 1'b1;
        if (capture) begin
          last_q <= data_in_monitor;
        end
      end
      if (do_write) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop && (overflow_count != 8'hFF)) begin
        overflow_count <= overflow_count + 8'd1;
      end
    end
  end

  // Storage needs no reset: an entry is only visible once written.
  always_ff @(posedge clk_monitor) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= new_evt;
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign evt_data   = evt_valid ? head.data   : '0;
  assign evt_strobe = evt_valid ? head.strobe : 1'b0;
`ifdef MONITOR_TIMESTAMP_EN
  assign evt_ts     = evt_valid ? head.ts     : '0;
`else
  assign evt_ts     = '0;
`endif

endmodule
